// File: rtl/riscv_defs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : riscv_defs_pkg
// Description : Shared definitions for the load/store path: funct3 access
//               encodings, the access-unit state encoding, the default bus
//               timeout, and the access legality/alignment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defs_pkg;

  // Default number of WAIT cycles before a bus error is raised
  localparam int TIMEOUT_DEFAULT = 255;

  // funct3 access encodings (loads and stores share B/H/W)
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mau_state_t;

  // An access is legal only for a defined funct3 and a naturally aligned
  // address. Unsigned variants exist for loads only.
  function automatic logic access_ok(input logic is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      c_f3_b:  ok = 1'b1;
      c_f3_h:  ok = ~off[0];
      c_f3_w:  ok = (off == 2'b00);
      c_f3_bu: ok = ~is_store;
      c_f3_hu: ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Purely combinational byte-lane steering. Store side builds
//               the write strobes and lane-replicated write data; load side
//               shifts the captured word down and sign/zero extends it.
// Ports       : st_funct3/st_off/store_data -> wstrb, wdata
//               ld_funct3/ld_off/ld_word    -> load_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import riscv_defs_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] load_data
);

  logic [31:0] w_shifted;

  // Data is replicated across all lanes so the strobes alone select the
  // destination byte(s); no per-lane data shift is needed.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0000_0000;
    case (st_funct3)
      c_f3_b: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{store_data[7:0]}};
      end
      c_f3_h: begin
        wstrb = 4'b0011 << st_off;
        wdata = {2{store_data[15:0]}};
      end
      c_f3_w: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  assign w_shifted = ld_word >> {ld_off, 3'b000};

  always_comb begin
    load_data = 32'h0000_0000;
    case (ld_funct3)
      c_f3_b:  load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      c_f3_h:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      c_f3_w:  load_data = w_shifted;
      c_f3_bu: load_data = {24'h0, w_shifted[7:0]};
      c_f3_hu: load_data = {16'h0, w_shifted[15:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store sequencer. Accepts one access from the
//               pipeline, stalls it, runs a single request/ack handshake to
//               data memory with a bus timeout, then pulses done for one
//               cycle with the formatted load result and fault flags.
// Ports       : clk, rstn                      - clock, async active-low reset
//               valid, mem_read, mem_write,
//               funct3, addr, store_data       - pipeline request
//               stall, done, load_data,
//               err_misalign, err_bus          - pipeline response
//               dmem_req/we/addr/wstrb/wdata,
//               dmem_rdata, dmem_ack           - data memory port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import riscv_defs_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misalign,
  output logic        err_bus,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [8:0] c_timeout = 9'(TIMEOUT);

  mau_state_t  r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_err_mis;
  logic        r_err_bus;

  logic        w_accept;
  logic        w_aligned;
  logic [8:0]  w_cnt_inc;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ld;

  // Gated by rstn so stall stays low while the unit is held in reset
  assign w_accept  = rstn & (r_state == ST_IDLE) & valid & (mem_read | mem_write);
  assign w_aligned = access_ok(mem_write, funct3, addr[1:0]);
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  lsu_lane_align u_lane (
    .st_funct3  (funct3),
    .st_off     (addr[1:0]),
    .store_data (store_data),
    .wstrb      (w_wstrb),
    .wdata      (w_wdata),
    .ld_funct3  (r_funct3),
    .ld_off     (r_off),
    .ld_word    (r_rdata),
    .load_data  (w_ld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'h0;
      r_wstrb   <= 4'h0;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_is_load <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= 2'b00;
      r_err_mis <= 1'b0;
      r_err_bus <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_load <= ~mem_write;
            r_funct3  <= funct3;
            r_off     <= addr[1:0];
            r_rdata   <= 32'h0;
            r_err_bus <= 1'b0;
            if (w_aligned) begin
              r_req   <= 1'b1;
              r_we    <= mem_write;
              r_addr  <= {addr[31:2], 2'b00};
              r_wstrb <= mem_write ? w_wstrb : 4'b0000;
              r_wdata <= mem_write ? w_wdata : 32'h0;
              r_cnt   <= 8'd0;
              r_state <= ST_WAIT;
            end else begin
              // Faulting access never touches the memory port
              r_err_mis <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          // An ack in the final allowed cycle takes priority over timeout
          if (dmem_ack) begin
            r_rdata <= dmem_rdata;
            r_req   <= 1'b0;
            r_state <= ST_RESP;
          end else if (w_cnt_inc == c_timeout) begin
            r_req     <= 1'b0;
            r_err_bus <= 1'b1;
            r_rdata   <= 32'h0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= w_cnt_inc[7:0];
          end
        end
        ST_RESP: begin
          r_err_mis <= 1'b0;
          r_err_bus <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall        = w_accept | (r_state == ST_WAIT);
  assign done         = (r_state == ST_RESP);
  assign err_misalign = r_err_mis;
  assign err_bus      = r_err_bus;
  assign load_data    = (done && r_is_load && !r_err_mis && !r_err_bus) ? w_ld : 32'h0;

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wstrb = r_wstrb;
  assign dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit. The driver computes the
//               expected memory request and pipeline response from a byte-
//               level memory model and queues them; a memory responder and a
//               response monitor pop and compare independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, err_misalign, err_bus;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .stall(stall), .done(done),
    .load_data(load_data), .err_misalign(err_misalign), .err_bus(err_bus),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          lat;
  } req_t;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        bus;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  logic [7:0]  ref_mem [int unsigned];   // model: byte addressed
  logic [31:0] dev_mem [int unsigned];   // responder: word addressed

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Access size in bytes, 0 for an undefined encoding
  function automatic int acc_size(input logic wr, input logic [2:0] f3);
    if (f3 == 3'b000 || (!wr && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!wr && f3 == 3'b101)) return 2;
    if (f3 == 3'b010) return 4;
    return 0;
  endfunction

  task automatic do_txn(input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int lat,
                        input logic use_exp, input logic [31:0] exp_ld);
    int sz, off, exp_cyc, cyc;
    logic mis, tmo, seen;
    req_t rq;
    resp_t rs;
    logic [31:0] v;
    sz  = acc_size(wr, f3);
    off = int'(a[1:0]);
    mis = (sz == 0) ? 1'b1 : ((off % sz) != 0);
    tmo = !mis && (lat > TMO);
    valid = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; store_data = sd;
    rs.ld = 32'h0; rs.mis = mis; rs.bus = tmo;
    if (!mis) begin
      rq.addr = {a[31:2], 2'b00}; rq.we = wr; rq.lat = lat;
      rq.wstrb = 4'h0; rq.wdata = 32'h0;
      if (wr) begin
        for (int j = 0; j < 4; j++) begin
          if (j >= off && j < off + sz) rq.wstrb[j] = 1'b1;
          rq.wdata[8*j +: 8] = sd[8*(j % sz) +: 8];
        end
      end
      req_q.push_back(rq);
      if (!tmo) begin
        if (wr) begin
          for (int i = 0; i < sz; i++) ref_mem[a + i] = sd[8*i +: 8];
        end else begin
          v = 32'h0;
          for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_rd(a + i);
          if (!f3[2] && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
          rs.ld = v;
        end
      end
    end
    if (use_exp) rs.ld = exp_ld;
    resp_q.push_back(rs);
    exp_cyc = mis ? 2 : (tmo ? TMO + 2 : lat + 2);
    cyc = 1;
    seen = 1'b0;
    @(negedge clk);
    chk("stall_accept", stall, 1'b1);
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else chk("stall_busy", stall, 1'b1);
    end
    chk("latency", cyc, exp_cyc);
    chk("stall_resp", stall, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      valid = 1'($urandom_range(0, 1)); mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("stall_idle", stall, 1'b0);
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  // Memory responder: checks each request against the queued expectation,
  // holds it for stability, and acks on the planned WAIT cycle.
  initial begin
    req_t cur;
    logic trk;
    int   wcnt;
    int unsigned w;
    trk = 1'b0; wcnt = 0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (!rstn) begin
        trk = 1'b0;
      end else if (dmem_req === 1'b1) begin
        if (!trk) begin
          if (req_q.size() == 0) begin
            chk("req_unexpected", dmem_req, 1'b0);
          end else begin
            cur = req_q.pop_front();
            trk = 1'b1; wcnt = 0;
            chk("dmem_addr", dmem_addr, cur.addr);
            chk("dmem_we", dmem_we, cur.we);
            chk("dmem_wstrb", dmem_wstrb, cur.wstrb);
            chk("dmem_wdata", dmem_wdata, cur.wdata);
          end
        end else begin
          chk("hold_addr", dmem_addr, cur.addr);
          chk("hold_wdata", dmem_wdata, cur.wdata);
        end
        if (trk) begin
          wcnt++;
          if (wcnt == cur.lat) begin
            w = dmem_addr >> 2;
            dmem_ack   = 1'b1;
            dmem_rdata = dev_mem.exists(w) ? dev_mem[w] : 32'h0;
            if (dmem_we) begin
              if (!dev_mem.exists(w)) dev_mem[w] = 32'h0;
              for (int j = 0; j < 4; j++)
                if (dmem_wstrb[j]) dev_mem[w][8*j +: 8] = dmem_wdata[8*j +: 8];
            end
          end
        end
      end else if (trk) begin
        chk("req_cycles", wcnt, (cur.lat <= TMO) ? cur.lat : TMO);
        trk = 1'b0;
      end
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (done === 1'b1) begin
          if (resp_q.size() == 0) begin
            chk("done_unexpected", done, 1'b0);
          end else begin
            e = resp_q.pop_front();
            chk("load_data", load_data, e.ld);
            chk("err_misalign", err_misalign, e.mis);
            chk("err_bus", err_bus, e.bus);
          end
        end else begin
          chk("quiet_load_data", load_data, 32'h0);
          chk("quiet_errs", {err_misalign, err_bus}, 2'b00);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic        wr, rd;
    rstn = 1'b0; valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    funct3 = 3'b010; addr = 32'h100; store_data = 32'h1234_5678;
    for (int w = 32'h100; w < 32'h140; w += 4) begin
      v = $urandom;
      dev_mem[w >> 2] = v;
      for (int i = 0; i < 4; i++) ref_mem[w + i] = v[8*i +: 8];
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dmem", {dmem_req, dmem_we, dmem_wstrb}, 6'h0);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      chk("rst_dmem_wdata", dmem_wdata, 32'h0);
      chk("rst_load", load_data, 32'h0);
      chk("rst_errs", {err_misalign, err_bus}, 2'b00);
    end
    @(posedge clk); #1;
    rstn = 1'b1;

    // Directed cases
    do_txn(1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 0, 0);
    do_txn(1, 0, 3'b000, 32'h103, 32'h0000_00A5, 1, 0, 0);
    do_txn(0, 1, 3'b000, 32'h103, 0, 1, 1, 32'hFFFF_FFA5);
    do_txn(0, 1, 3'b100, 32'h103, 0, 2, 1, 32'h0000_00A5);
    do_txn(1, 0, 3'b010, 32'h100, 32'h8001_0000, 1, 0, 0);
    do_txn(0, 1, 3'b001, 32'h102, 0, 1, 1, 32'hFFFF_8001);
    do_txn(0, 1, 3'b101, 32'h102, 0, 3, 1, 32'h0000_8001);
    do_txn(0, 1, 3'b010, 32'h102, 0, 1, 0, 0);
    do_txn(0, 1, 3'b010, 32'h104, 0, TMO + 1, 0, 0);
    do_txn(0, 1, 3'b010, 32'h104, 0, TMO, 0, 0);
    do_txn(1, 1, 3'b010, 32'h108, 32'hCAFE_F00D, 2, 0, 0);
    do_txn(0, 1, 3'b010, 32'h108, 0, 1, 1, 32'hCAFE_F00D);
    do_txn(1, 0, 3'b011, 32'h10C, 32'h1111_1111, 1, 0, 0);

    // Reset pulse in the middle of a WAIT
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h104;
    req_q.push_back('{addr: 32'h104, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, lat: 100});
    @(negedge clk);
    chk("rw_stall_accept", stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("rw_req_before", dmem_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rw_req_dropped", dmem_req, 1'b0);
    chk("rw_stall", stall, 1'b0);
    chk("rw_done", done, 1'b0);
    valid = 1'b0; mem_read = 1'b0;
    repeat (2) @(negedge clk);
    req_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    do_txn(0, 1, 3'b010, 32'h0, 0, 1, 1, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(wr, rd, 3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 63)),
             $urandom, $urandom_range(1, TMO + 2), 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    repeat (5) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
Parameters:
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT cycles before a bus error (range 1..255).
Ports:
REQ-002 The block SHALL have port clk  input  1  single system clock, rising-edge.
REQ-003 The block SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port valid  input  1  MEM-stage instruction present; all other inputs are held stable while stall=1.
REQ-005 The block SHALL have ports mem_read and mem_write  input  1 each  load and store request; mem_write wins if both are set.
REQ-006 The block SHALL have port funct3  input  3  access type: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-007 The block SHALL have ports addr  input  32  byte address, and store_data  input  32  store value in low lanes.
REQ-008 The block SHALL have ports stall  output  1  freeze pipeline; done  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have ports load_data  output  32  extended load result, and err_misalign, err_bus  output  1 each  fault flags valid with done.
REQ-010 The block SHALL have ports dmem_req  output  1, dmem_we  output  1, dmem_addr  output  32 (word aligned, [1:0]=0), dmem_wstrb  output  4, dmem_wdata  output  32.
REQ-011 The block SHALL have ports dmem_rdata  input  32 and dmem_ack  input  1  one-cycle completion from memory/MMIO.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-013 Accept condition: state IDLE and valid and (mem_read or mem_write).
REQ-014 On accept, the block SHALL assert stall combinationally in the same cycle.
REQ-015 On an aligned accept, the block SHALL register the word address, we, wstrb and lane-shifted wdata, then go to WAIT.
REQ-016 Alignment rules: byte accesses are always aligned; halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
REQ-017 On a misaligned accept, the block SHALL go straight to RESP with err_misalign=1, drive no dmem_req, and leave memory unmodified.
REQ-018 In WAIT, dmem_req SHALL be 1 and dmem_addr/we/wstrb/wdata SHALL be held constant until dmem_ack, and stall SHALL be 1.
REQ-019 On dmem_ack in WAIT, the block SHALL capture dmem_rdata, drop dmem_req in the next cycle, and go to RESP.
REQ-020 The timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-021 When the counter reaches TIMEOUT, the block SHALL drop dmem_req, go to RESP with err_bus=1, and set load_data=0.
REQ-022 If ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and err_bus SHALL be 0.
REQ-023 In RESP, the block SHALL hold done=1 and stall=0 for exactly one cycle, then go to IDLE; no request is accepted in RESP.
REQ-024 Minimum aligned latency SHALL be 3 cycles: accept, WAIT with ack, RESP.
REQ-025 Store strobes and data:
- SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
- SH: wstrb = 0011 << addr[1:0]; wdata = half replicated x2.
- SW: wstrb = 1111; wdata = store_data.
- Any other store funct3 SHALL be treated as misaligned.
REQ-026 Load data formation:
- The block SHALL shift the captured word right by 8*addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- Halfword sign SHALL come from bit 15.
- Any other load funct3 SHALL return 0 with err_misalign=1.
REQ-027 For loads, dmem_we=0 and dmem_wstrb=0000; load_data SHALL be 0 for stores and outside RESP.

Reset
REQ-028 While rstn=0, the block SHALL be in state IDLE with counter=0 and all outputs 0 (stall, done, errors, dmem_*, load_data).
REQ-029 Reset asserted during WAIT SHALL drop dmem_req asynchronously and abandon the access with no done pulse.
REQ-030 After rstn rises, the first accept SHALL be possible on the first clock edge.

Structure
REQ-031 The funct3 encodings, the state encoding, and the TIMEOUT default SHALL live in the shared riscv_defs header/package.
REQ-032 The block SHALL contain one sub-module, lsu_lane_align, which is combinational and covers store strobe/data shift and load shift/extend.
REQ-033 The FSM, counter, and request registers SHALL reside in mem_access_unit.

Verification
REQ-034 SW at addr 0x100, data 0xDEADBEEF, ack on 1st WAIT cycle -> wstrb 1111, dmem_addr 0x100, done in cycle 3, stall high in cycles 1-2.
REQ-035 SB at addr 0x103, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5; then LB at 0x103 with rdata 0xA5000000 -> load_data 0xFFFFFFA5; LBU at 0x103 -> 0x000000A5.
REQ-036 LH at 0x102 with rdata 0x80010000 -> 0xFFFF8001; LHU -> 0x00008001; LW at 0x102 -> err_misalign=1, dmem_req never asserted.
REQ-037 TIMEOUT=4 with no ack -> dmem_req high 4 cycles, then done with err_bus=1 and load_data=0; ack coincident with the 4th cycle -> err_bus=0.
REQ-038 rstn pulsed low during WAIT -> dmem_req 0 immediately, no done pulse; next LW at 0x0 completes normally.
REQ-039 Back-to-back SW then LW at the same address -> second access accepted in the IDLE cycle after RESP, and the read returns the written word.
